// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer driving a 1-bit ALU slice LSB-first and assembling the result.
// Optional signed-overflow flag enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  output logic             slice_a,
  output logic             slice_b,
  output logic [2:0]       slice_sel,
  output logic             slice_cin,
  input  logic             slice_out,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_ovf
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [WIDTH-2:0] r_res;
  logic [2:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_in_ready, r_out_valid, r_cout, r_zero;
  logic             w_run, w_arith, w_last;
  logic [WIDTH-1:0] w_shift;
  assign w_run   = r_state == S_RUN;
  assign w_arith = r_sel == 3'b110 || r_sel == 3'b101;
  assign w_last  = r_cnt == CNT_W'(WIDTH - 1);
  // Incoming bit lands on top; on the last edge this is the complete word.
  assign w_shift = {slice_out, r_res};
  assign slice_a    = w_run ? r_a[0] : 1'b0;
  assign slice_b    = w_run ? r_b[0] : 1'b0;
  assign slice_sel  = w_run ? r_sel : 3'b000;
  assign slice_cin  = w_run ? r_carry : 1'b0;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_cout   = r_cout;
  assign out_zero   = r_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a        <= in_a;
          r_b        <= in_b;
          r_sel      <= in_sel;
          r_carry    <= in_sel == 3'b101;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_res   <= w_shift[WIDTH-1:1];
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= slice_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_shift;
            r_cout      <= w_arith & slice_cout;
            r_zero      <= ~|w_shift;
          end
        end
        S_DONE: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef ALU_SERIAL_OVF_EN
  logic r_ovf;
  // Carry into the MSB is r_carry on the last edge; XOR with carry out gives signed overflow.
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_run && w_last) r_ovf <= w_arith & (r_carry ^ slice_cout);
  end
  assign out_ovf = r_ovf;
`else
  assign out_ovf = 1'b0;
`endif
endmodule
